// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg: shared FSM state encodings and memory-request constants
// for the icache/dcache arbiter and its capture sub-module.
package mem_req_arbiter_pkg;

  // Arbiter FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_D_REQ  = 3'd1,
    ST_D_WAIT = 3'd2,
    ST_I_REQ  = 3'd3,
    ST_I_WAIT = 3'd4
  } arb_state_e;

  // A zero byte mask on the memory port means a read.
  localparam logic [3:0] WMASK_READ = 4'b0000;

  // True when a byte-enable vector describes a write access.
  function automatic logic is_write(input logic [3:0] we);
    return we != WMASK_READ;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: shared memory port with a valid/ready request channel
// and a valid-only response channel (one response per accepted request).
interface mem_req_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [3:0]        mem_req_wmask;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  // Arbiter side: issues requests, receives responses.
  modport master (
    output mem_req_valid, mem_req_addr, mem_req_wmask, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  // Memory side: accepts requests, returns responses.
  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_wmask, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/mem_req_arbiter_capture.sv
// mem_req_capture: holds one core port's pending flag together with the
// word-aligned address and an opaque payload (byte enables/store data).
// The pending flag follows the request on every capture cycle and is cleared
// when the arbiter retires the access; address/payload only load when a
// request is present, so they keep describing the last issued access.
module mem_req_capture #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned PAYLOAD_W = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_capture,
  input  logic                 i_req,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [PAYLOAD_W-1:0] i_payload,
  input  logic                 i_clear,
  output logic                 o_pend,
  output logic [ADDR_W-1:0]    o_addr,
  output logic [PAYLOAD_W-1:0] o_payload
);

  logic                 r_pend;
  logic [ADDR_W-1:0]    r_addr;
  logic [PAYLOAD_W-1:0] r_payload;

  // Capture the core request while unstalled, clear pending on retirement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend    <= 1'b0;
      r_addr    <= '0;
      r_payload <= '0;
    end else if (i_capture) begin
      r_pend <= i_req;
      if (i_req) begin
        r_addr    <= i_addr;
        r_payload <= i_payload;
      end
    end else if (i_clear) begin
      r_pend <= 1'b0;
    end
  end

  assign o_pend    = r_pend;
  assign o_addr    = r_addr;
  assign o_payload = r_payload;

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: serializes Riscv151 icache and dcache accesses onto one
// valid/ready memory port, stalling the core until every captured access has
// been answered. Data accesses go before instruction fetches.
// Optional build macro MEM_REQ_ARBITER_PERF_EN adds stall-cycle and
// request-handshake counters (perf_stall_cycles, perf_mem_reqs).
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              icache_re,
  output logic [DATA_W-1:0] icache_dout,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic              dcache_re,
  input  logic [3:0]        dcache_we,
  input  logic [DATA_W-1:0] dcache_din,
  output logic [DATA_W-1:0] dcache_dout,
  output logic              stall,
  mem_req_arbiter_if.master mem
`ifdef MEM_REQ_ARBITER_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_mem_reqs
`endif
);

  localparam int unsigned D_PAYLOAD_W = 4 + DATA_W;

  arb_state_e        r_state;
  logic              r_stall;
  logic              r_req_valid;
  logic              r_sel_d;
  logic [DATA_W-1:0] r_icache_dout;
  logic [DATA_W-1:0] r_dcache_dout;

  logic                   w_capture;
  logic                   w_d_req;
  logic [ADDR_W-1:0]      w_i_addr_aligned;
  logic [ADDR_W-1:0]      w_d_addr_aligned;
  logic                   w_i_clear;
  logic                   w_d_clear;
  logic                   w_i_pend;
  logic                   w_d_pend;
  logic [ADDR_W-1:0]      w_i_addr_q;
  logic [ADDR_W-1:0]      w_d_addr_q;
  logic [D_PAYLOAD_W-1:0] w_d_payload_q;
  logic [3:0]             w_d_we_q;
  logic [DATA_W-1:0]      w_d_din_q;
  logic                   w_handshake;
  logic                   w_unused_i_payload;
  logic                   w_unused_bits;

  assign w_capture        = !r_stall;
  assign w_d_req          = dcache_re | is_write(dcache_we);
  assign w_i_addr_aligned = {icache_addr[ADDR_W-1:2], 2'b00};
  assign w_d_addr_aligned = {dcache_addr[ADDR_W-1:2], 2'b00};
  assign w_i_clear        = (r_state == ST_I_WAIT) && mem.mem_resp_valid;
  assign w_d_clear        = (r_state == ST_D_WAIT) && mem.mem_resp_valid;
  assign w_handshake      = r_req_valid && mem.mem_req_ready;
  assign w_d_we_q         = w_d_payload_q[DATA_W+3:DATA_W];
  assign w_d_din_q        = w_d_payload_q[DATA_W-1:0];
  // Byte-offset bits never reach the word-aligned memory port.
  assign w_unused_bits    = ^{icache_addr[1:0], dcache_addr[1:0], w_unused_i_payload};

  mem_req_capture #(
    .ADDR_W   (ADDR_W),
    .PAYLOAD_W(1)
  ) u_icap (
    .clk      (clk),
    .reset    (reset),
    .i_capture(w_capture),
    .i_req    (icache_re),
    .i_addr   (w_i_addr_aligned),
    .i_payload(1'b0),
    .i_clear  (w_i_clear),
    .o_pend   (w_i_pend),
    .o_addr   (w_i_addr_q),
    .o_payload(w_unused_i_payload)
  );

  mem_req_capture #(
    .ADDR_W   (ADDR_W),
    .PAYLOAD_W(D_PAYLOAD_W)
  ) u_dcap (
    .clk      (clk),
    .reset    (reset),
    .i_capture(w_capture),
    .i_req    (w_d_req),
    .i_addr   (w_d_addr_aligned),
    .i_payload({dcache_we, dcache_din}),
    .i_clear  (w_d_clear),
    .o_pend   (w_d_pend),
    .o_addr   (w_d_addr_q),
    .o_payload(w_d_payload_q)
  );

  // Arbitration FSM; stall, request-valid, port select and read data are all
  // registered here. IDLE decides from the live core request because the
  // capture registers load on that very edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_stall       <= 1'b0;
      r_req_valid   <= 1'b0;
      r_sel_d       <= 1'b0;
      r_icache_dout <= '0;
      r_dcache_dout <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_d_req) begin
            r_state     <= ST_D_REQ;
            r_stall     <= 1'b1;
            r_req_valid <= 1'b1;
            r_sel_d     <= 1'b1;
          end else if (icache_re) begin
            r_state     <= ST_I_REQ;
            r_stall     <= 1'b1;
            r_req_valid <= 1'b1;
            r_sel_d     <= 1'b0;
          end
        end
        ST_D_REQ: begin
          if (mem.mem_req_ready) begin
            r_state     <= ST_D_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        ST_D_WAIT: begin
          if (mem.mem_resp_valid) begin
            if (!is_write(w_d_we_q)) begin
              r_dcache_dout <= mem.mem_resp_data;
            end
            if (w_i_pend) begin
              r_state     <= ST_I_REQ;
              r_req_valid <= 1'b1;
              r_sel_d     <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_stall <= 1'b0;
            end
          end
        end
        ST_I_REQ: begin
          if (mem.mem_req_ready) begin
            r_state     <= ST_I_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        ST_I_WAIT: begin
          if (mem.mem_resp_valid) begin
            r_icache_dout <= mem.mem_resp_data;
            r_state       <= ST_IDLE;
            r_stall       <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_stall     <= 1'b0;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  // Address/data come straight from the selected capture registers, which
  // only reload when a new access is issued, so they hold between requests.
  assign mem.mem_req_valid = r_req_valid;
  assign mem.mem_req_addr  = r_sel_d ? w_d_addr_q : w_i_addr_q;
  assign mem.mem_req_wmask = (r_req_valid && r_sel_d) ? w_d_we_q : WMASK_READ;
  assign mem.mem_req_wdata = w_d_din_q;

  assign stall       = r_stall;
  assign icache_dout = r_icache_dout;
  assign dcache_dout = r_dcache_dout;

`ifdef MEM_REQ_ARBITER_PERF_EN
  logic [31:0] r_perf_stall_cycles;
  logic [31:0] r_perf_mem_reqs;

  // Free-running, wrapping counters of stalled cycles and accepted requests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_stall_cycles <= '0;
      r_perf_mem_reqs     <= '0;
    end else begin
      if (r_stall) begin
        r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
      end
      if (w_handshake) begin
        r_perf_mem_reqs <= r_perf_mem_reqs + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = r_perf_stall_cycles;
  assign perf_mem_reqs     = r_perf_mem_reqs;
`else
  logic w_unused_handshake;
  assign w_unused_handshake = w_handshake;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: scoreboard bench. Each access pushes its expected
// memory requests (with the read data the memory model will return); the
// memory model pops and compares them on every handshake, and the core-side
// results are checked against a small reference model once stall drops.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    bit          chk_wdata;
    logic [31:0] rdata;
  } req_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] icache_addr = '0;
  logic          icache_re = 1'b0;
  logic [DW-1:0] icache_dout;
  logic [AW-1:0] dcache_addr = '0;
  logic          dcache_re = 1'b0;
  logic [3:0]    dcache_we = '0;
  logic [DW-1:0] dcache_din = '0;
  logic [DW-1:0] dcache_dout;
  logic          stall;
`ifdef MEM_REQ_ARBITER_PERF_EN
  logic [31:0]   perf_stall_cycles;
  logic [31:0]   perf_mem_reqs;
`endif

  mem_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .icache_addr(icache_addr),
    .icache_re  (icache_re),
    .icache_dout(icache_dout),
    .dcache_addr(dcache_addr),
    .dcache_re  (dcache_re),
    .dcache_we  (dcache_we),
    .dcache_din (dcache_din),
    .dcache_dout(dcache_dout),
    .stall      (stall),
    .mem        (mem_if)
`ifdef MEM_REQ_ARBITER_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_mem_reqs    (perf_mem_reqs)
`endif
  );

  always #5 clk = ~clk;

  req_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned bp_left = 0;
  bit          hold_resp = 1'b0;
  bit          resp_pend = 1'b0;
  logic [31:0] resp_data_q = '0;
  bit          spur_req = 1'b0;
  logic [31:0] spur_data = '0;
  logic [31:0] exp_idout = '0;
  logic [31:0] exp_ddout = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: decides ready and drives responses at negedges.
  initial begin
    req_t e;
    mem_if.mem_req_ready  = 1'b1;
    mem_if.mem_resp_valid = 1'b0;
    mem_if.mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      mem_if.mem_resp_valid = 1'b0;
      if (resp_pend && !hold_resp) begin
        mem_if.mem_resp_valid = 1'b1;
        mem_if.mem_resp_data  = resp_data_q;
        resp_pend = 1'b0;
      end else if (spur_req) begin
        mem_if.mem_resp_valid = 1'b1;
        mem_if.mem_resp_data  = spur_data;
        spur_req = 1'b0;
      end
      if (mem_if.mem_req_valid && bp_left > 0) begin
        mem_if.mem_req_ready = 1'b0;
        bp_left--;
        if (exp_q.size() > 0) begin
          check("bp_hold_addr", mem_if.mem_req_addr, exp_q[0].addr);
          check("bp_hold_wmask", 32'(mem_if.mem_req_wmask), 32'(exp_q[0].wmask));
        end
      end else begin
        mem_if.mem_req_ready = 1'b1;
        if (mem_if.mem_req_valid) begin
          check("req_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("req_addr", mem_if.mem_req_addr, e.addr);
            check("req_wmask", 32'(mem_if.mem_req_wmask), 32'(e.wmask));
            if (e.chk_wdata) check("req_wdata", mem_if.mem_req_wdata, e.wdata);
            resp_pend   = 1'b1;
            resp_data_q = e.rdata;
          end
        end
      end
    end
  end

  // Drive one capture cycle, queue expected requests, measure the stall.
  task automatic access(input string tag,
                        input bit ire, input logic [31:0] ia, input logic [31:0] irdata,
                        input bit dre, input logic [3:0] dwe, input logic [31:0] da,
                        input logic [31:0] din, input logic [31:0] drdata,
                        input int unsigned bp);
    req_t e;
    bit dreq;
    int unsigned n;
    int unsigned exp_n;
    dreq = dre || (dwe != 4'b0000);
    @(negedge clk);
    icache_re = ire; icache_addr = ia;
    dcache_re = dre; dcache_we = dwe; dcache_addr = da; dcache_din = din;
    bp_left = (dreq || ire) ? bp : 0;
    if (dreq) begin
      e.addr = {da[31:2], 2'b00}; e.wmask = dwe; e.wdata = din;
      e.chk_wdata = 1'b1; e.rdata = drdata;
      exp_q.push_back(e);
      if (dwe == 4'b0000) exp_ddout = drdata;
    end
    if (ire) begin
      e.addr = {ia[31:2], 2'b00}; e.wmask = 4'b0000; e.wdata = '0;
      e.chk_wdata = 1'b0; e.rdata = irdata;
      exp_q.push_back(e);
      exp_idout = irdata;
    end
    exp_n = (dreq ? 2 : 0) + (ire ? 2 : 0) + ((dreq || ire) ? bp : 0);
    @(posedge clk);
    #1;
    icache_re = 1'b0; dcache_re = 1'b0; dcache_we = 4'b0000;
    n = 0;
    @(negedge clk);
    while (stall === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_stall_cycles"}, 32'(n), 32'(exp_n));
    check({tag, "_icache_dout"}, icache_dout, exp_idout);
    check({tag, "_dcache_dout"}, dcache_dout, exp_ddout);
    check({tag, "_reqs_consumed"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t e;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req_valid", 32'(mem_if.mem_req_valid), 32'd0);
    check("rst_req_wmask", 32'(mem_if.mem_req_wmask), 32'd0);
    check("rst_req_addr", mem_if.mem_req_addr, 32'd0);
    check("rst_req_wdata", mem_if.mem_req_wdata, 32'd0);
    check("rst_icache_dout", icache_dout, 32'd0);
    check("rst_dcache_dout", dcache_dout, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    access("fetch", 1'b1, 32'h0000_1004, 32'h0000_0013,
           1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 0);
    access("fetch_load", 1'b1, 32'h0000_0100, 32'h0000_0033,
           1'b1, 4'b0000, 32'h0000_2002, 32'h0, 32'h1111_2222, 0);
    access("store", 1'b0, 32'h0, 32'h0,
           1'b1, 4'b0011, 32'h0000_3000, 32'hDEAD_BEEF, 32'h5555_5555, 0);
    access("backpressure", 1'b0, 32'h0, 32'h0,
           1'b1, 4'b0000, 32'h0000_4008, 32'h0, 32'h7777_8888, 5);
    access("store_fetch_bp", 1'b1, 32'h0000_0204, 32'h0000_0093,
           1'b0, 4'b1111, 32'h0000_5004, 32'h0123_4567, 32'h9999_9999, 2);
    access("no_request", 1'b0, 32'h0, 32'h0,
           1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 0);

    for (int i = 0; i < 10; i++) begin
      access("random", 1'($urandom_range(0, 1)), $urandom(), $urandom(),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000,
             $urandom(), $urandom(), $urandom(), $urandom_range(0, 2));
    end

    // Spurious response while idle must be ignored.
    @(posedge clk);
    #1;
    spur_data = 32'hFFFF_FFFF;
    spur_req  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("spurious_stall", 32'(stall), 32'd0);
    end
    check("spurious_icache_dout", icache_dout, exp_idout);
    check("spurious_dcache_dout", dcache_dout, exp_ddout);

    // Reset while the data access waits for its response.
    hold_resp = 1'b1;
    @(negedge clk);
    dcache_re = 1'b1; dcache_addr = 32'h0000_6004; dcache_din = 32'h0;
    e.addr = 32'h0000_6004; e.wmask = 4'b0000; e.wdata = 32'h0;
    e.chk_wdata = 1'b1; e.rdata = 32'hABCD_0123;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    dcache_re = 1'b0;
    @(posedge clk);
    #3;
    check("dwait_stall", 32'(stall), 32'd1);
    reset = 1'b0;
    #1;
    check("arst_stall", 32'(stall), 32'd0);
    check("arst_req_valid", 32'(mem_if.mem_req_valid), 32'd0);
    check("arst_req_wmask", 32'(mem_if.mem_req_wmask), 32'd0);
    check("arst_req_addr", mem_if.mem_req_addr, 32'd0);
    check("arst_req_wdata", mem_if.mem_req_wdata, 32'd0);
    check("arst_icache_dout", icache_dout, 32'd0);
    check("arst_dcache_dout", dcache_dout, 32'd0);
    exp_idout = '0;
    exp_ddout = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    hold_resp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("stale_resp_stall", 32'(stall), 32'd0);
    end
    check("stale_resp_delivered", 32'(resp_pend), 32'd0);
    check("stale_resp_dcache_dout", dcache_dout, exp_ddout);
    check("stale_resp_icache_dout", icache_dout, exp_idout);

    access("post_reset_load", 1'b0, 32'h0, 32'h0,
           1'b1, 4'b0000, 32'h0000_7000, 32'h0, 32'h2468_ACE0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
Memory-side block directly downstream of the Riscv151 core. It consumes the core's icache and dcache request ports and drives the core's stall input. It serializes instruction and data accesses onto one shared memory port that uses a valid/ready request and valid response handshake. To the core it presents synchronous-memory semantics: read data is returned on the cycle stall deasserts and then held.

Parameters:
ADDR_W, 32, core and memory address width
DATA_W, 32, data word width; must be 32 (byte mask is 4 bits)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
icache_addr  input  ADDR_W  instruction fetch address from core
icache_re  input  1  instruction read request
icache_dout  output  DATA_W  fetched instruction, registered
dcache_addr  input  ADDR_W  data access address from core
dcache_re  input  1  data read request
dcache_we  input  4  byte write enables
dcache_din  input  DATA_W  store data
dcache_dout  output  DATA_W  load data, registered
stall  output  1  freezes core while transactions are outstanding
mem_req_valid  output  1  request to memory
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  ADDR_W  word-aligned address: {addr[ADDR_W-1:2], 2'b00}
mem_req_wmask  output  4  0 = read; nonzero = write byte mask
mem_req_wdata  output  DATA_W  write data
mem_resp_valid  input  1  response (read data or write ack), one per request
mem_resp_data  input  DATA_W  read data

Behaviour:
- Capture: on a rising edge with stall=0, register the request state.
  - ipend <= icache_re, with its address.
  - dpend <= (dcache_re | (dcache_we != 0)), with address, we and din.
  - If dcache_we != 0, the access is a write even when dcache_re is also set.
- FSM states: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT. stall = (state != IDLE); stall is registered (no combinational path from inputs).
- IDLE: on capture, go to D_REQ if dpend, else I_REQ if ipend, else stay in IDLE.
- D_REQ/I_REQ: mem_req_valid=1, with addr/wmask/wdata taken from the captured registers.
  - A handshake occurs when mem_req_ready=1 in the same cycle; then go to the matching *_WAIT state.
  - Request fields stay stable while valid=1 and ready=0.
- D_WAIT: on mem_resp_valid, load dcache_dout <= mem_resp_data if the access is a read (dcache_dout unchanged for a write), clear dpend, then go to I_REQ if ipend, else IDLE.
- I_WAIT: on mem_resp_valid, icache_dout <= mem_resp_data, clear ipend, go to IDLE.
- Priority: dcache before icache when both are pending in the same capture.
- mem_resp_valid in IDLE, D_REQ or I_REQ is ignored (no state or data change).
- Outputs in non-REQ states: mem_req_valid=0, mem_req_wmask=0, and addr/wdata hold their last values.
- Latency: with ready=1 and a response the cycle after acceptance:
  - single access: stall high for 2 cycles;
  - both i and d: stall high for 4 cycles.
- Data outputs hold their values until overwritten by a later response of the same type.
- Reset (asserted at any time, including mid-transaction):
  - state=IDLE, ipend=dpend=0;
  - icache_dout=0, dcache_dout=0, stall=0, mem_req_valid=0, mem_req_wmask=0, mem_req_addr=0, mem_req_wdata=0.
  - Responses outstanding from before reset are ignored because the FSM is in IDLE.

Optional Feature:
Macro MEM_REQ_ARBITER_PERF_EN.
- Defined: adds output perf_stall_cycles (32 bits), which increments every cycle stall=1, wraps at 2^32 and resets to 0. Also adds output perf_mem_reqs (32 bits), which increments on every request handshake, wraps and resets to 0.
- Not defined: both ports and their counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/header (alongside const.vh): FSM state encodings (3 bits), and the WMASK_READ = 4'b0000 constant.
- One natural sub-module, mem_req_capture: holds the pending flag plus address/we/din registers, instantiated once for icache and once for dcache. The FSM stays in the parent.

Test Plan:
- Fetch only: icache_re=1, addr 0x0000_1004, ready=1, resp next cycle with 0x0000_0013 -> mem_req_addr=0x0000_1004, wmask=0, stall high for exactly 2 cycles, then icache_dout=0x0000_0013.
- Simultaneous fetch at 0x100 and load at 0x2002 -> first request addr=0x2000 (data first), second 0x100; stall high for 4 cycles; dcache_dout and icache_dout carry their respective response data.
- Store with dcache_we=4'b0011, dcache_re=1, din=0xDEAD_BEEF -> mem_req_wmask=0011, wdata=0xDEADBEEF; after the ack, dcache_dout is unchanged.
- Back-pressure: mem_req_ready held 0 for 5 cycles -> mem_req_valid, addr and wmask stay stable and stall stays 1; handshake on the 6th cycle.
- Spurious mem_resp_valid in IDLE with data 0xFFFF_FFFF -> no change on icache_dout or dcache_dout, stall stays 0.
- Reset asserted (reset=0) during D_WAIT -> outputs go to 0 immediately (async); after release, a response arriving for the old request is ignored and stall=0.
